// File: rtl/bpf_defs.sv
// Shared definitions for the BPF packet snooper: default widths, FSM states and
// the tkeep-to-byte-count helper.
package bpf_defs;

  localparam int unsigned PACKET_BYTE_ADDR_WIDTH_DEF = 12;
  localparam int unsigned PACKET_ADDR_WIDTH_DEF      = PACKET_BYTE_ADDR_WIDTH_DEF - 2;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDone
  } snoop_state_e;

  // Leading ones from bit 3; tkeep is contiguous, so this is the valid byte count.
  function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (keep[i] && (n == 3'(3 - i))) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bpf_snooper.sv
// Captures one AXI-Stream packet into the bpfvm packet buffer, one word per beat,
// and reports its byte length once the final write has been issued.
module bpf_snooper
  import bpf_defs::*;
#(
  parameter int unsigned PACKET_BYTE_ADDR_WIDTH = PACKET_BYTE_ADDR_WIDTH_DEF,
  parameter int unsigned PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       s_axis_tdata,
  input  logic [3:0]                        s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [PACKET_ADDR_WIDTH-1:0]      snooper_wr_addr,
  output logic [31:0]                       snooper_wr_data,
  output logic                              snooper_wr_en,
  output logic                              snooper_done,
  input  logic                              ready_for_snooper,
  output logic [PACKET_BYTE_ADDR_WIDTH:0]   pkt_byte_len,
  output logic                              pkt_truncated
);

  localparam int unsigned CntW  = PACKET_ADDR_WIDTH + 1;
  localparam int unsigned LenW  = PACKET_BYTE_ADDR_WIDTH + 1;
  localparam int unsigned LenW1 = LenW + 1;
  localparam logic [CntW-1:0]  Capacity = CntW'(1) << PACKET_ADDR_WIDTH;
  localparam logic [LenW1-1:0] MaxBytes = LenW1'(1) << (PACKET_ADDR_WIDTH + 2);

  snoop_state_e    state_q;
  logic [CntW-1:0] beat_cnt_q;
  logic [LenW-1:0] byte_cnt_q;
  logic            trunc_q;

  logic             beat_acc;
  logic             in_range;
  logic [2:0]       beat_bytes;
  logic [LenW1-1:0] byte_sum;
  logic [LenW-1:0]  byte_next;

  assign beat_acc   = s_axis_tvalid && s_axis_tready;
  assign in_range   = beat_cnt_q < Capacity;
  assign beat_bytes = s_axis_tlast ? keep_bytes(s_axis_tkeep) : 3'd4;
  assign byte_sum   = {1'b0, byte_cnt_q} + LenW1'(beat_bytes);
  assign byte_next  = (byte_sum > MaxBytes) ? MaxBytes[LenW-1:0] : byte_sum[LenW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      s_axis_tready   <= 1'b0;
      snooper_wr_en   <= 1'b0;
      snooper_wr_addr <= '0;
      snooper_wr_data <= '0;
      snooper_done    <= 1'b0;
      pkt_byte_len    <= '0;
      pkt_truncated   <= 1'b0;
      beat_cnt_q      <= '0;
      byte_cnt_q      <= '0;
      trunc_q         <= 1'b0;
    end else begin
      snooper_wr_en <= 1'b0;
      snooper_done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The VM still sees the done pulse on this edge and has not yet dropped ready.
          if (ready_for_snooper && !snooper_done) begin
            state_q       <= StRecv;
            s_axis_tready <= 1'b1;
            beat_cnt_q    <= '0;
            byte_cnt_q    <= '0;
            trunc_q       <= 1'b0;
          end
        end
        StRecv: begin
          if (beat_acc) begin
            byte_cnt_q <= byte_next;
            if (in_range) begin
              beat_cnt_q <= beat_cnt_q + CntW'(1);
              if (!(s_axis_tlast && (s_axis_tkeep == 4'd0))) begin
                snooper_wr_en   <= 1'b1;
                snooper_wr_addr <= beat_cnt_q[PACKET_ADDR_WIDTH-1:0];
                snooper_wr_data <= s_axis_tdata;
              end
            end else begin
              trunc_q <= 1'b1;
            end
            if (s_axis_tlast) begin
              state_q       <= StDone;
              s_axis_tready <= 1'b0;
            end
          end
        end
        StDone: begin
          state_q       <= StIdle;
          snooper_done  <= 1'b1;
          pkt_byte_len  <= byte_cnt_q;
          pkt_truncated <= trunc_q;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bpf_snooper.sv
// Bench for bpf_snooper with a 16-word buffer: directed vector table, hand-written
// stall and reset sequences, and random packets against a packet-level model.
module tb_bpf_snooper;

  localparam int BW  = 6;
  localparam int AW  = BW - 2;
  localparam int CAP = 1 << AW;
  localparam int NV  = 9;

  logic          clk;
  logic          rst;
  logic [31:0]   s_axis_tdata;
  logic [3:0]    s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [AW-1:0] snooper_wr_addr;
  logic [31:0]   snooper_wr_data;
  logic          snooper_wr_en;
  logic          snooper_done;
  logic          ready_for_snooper;
  logic [BW:0]   pkt_byte_len;
  logic          pkt_truncated;

  bpf_snooper #(
    .PACKET_BYTE_ADDR_WIDTH(BW),
    .PACKET_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .snooper_wr_addr(snooper_wr_addr),
    .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en),
    .snooper_done(snooper_done),
    .ready_for_snooper(ready_for_snooper),
    .pkt_byte_len(pkt_byte_len),
    .pkt_truncated(pkt_truncated)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    int len;
    bit trunc;
    int cyc;
  } done_t;

  typedef struct {
    int          n;
    logic [3:0]  keep;
    int          gap;
    logic [31:0] first;
    logic [31:0] last;
    int          exp_wr;
    int          exp_len;
    bit          exp_tr;
  } vec_t;

  wr_t         wr_q[$];
  done_t       done_q[$];
  logic [31:0] pkt_words[$];
  logic [3:0]  pkt_keep;
  int          pkt_gap;
  vec_t        vecs[NV];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (snooper_wr_en) wr_q.push_back('{int'(snooper_wr_addr), snooper_wr_data, cyc});
    if (snooper_done) done_q.push_back('{int'(pkt_byte_len), pkt_truncated, cyc});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic int lead_bytes(input logic [3:0] k);
    case (k)
      4'hF:    return 4;
      4'hE:    return 3;
      4'hC:    return 2;
      4'h8:    return 1;
      default: return 0;
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tready"}, s_axis_tready, 0);
    chk({tag, "_wr_en"}, snooper_wr_en, 0);
    chk({tag, "_wr_addr"}, snooper_wr_addr, 0);
    chk({tag, "_wr_data"}, snooper_wr_data, 0);
    chk({tag, "_done"}, snooper_done, 0);
    chk({tag, "_len"}, pkt_byte_len, 0);
    chk({tag, "_trunc"}, pkt_truncated, 0);
  endtask

  // Called mid-cycle; ready is raised for the start and dropped once a beat is taken.
  task automatic send_packet();
    int i;
    int guard;
    int n;
    bit acc;
    n = pkt_words.size();
    i = 0;
    guard = 0;
    ready_for_snooper = 1'b1;
    while (i < n && guard < 500) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pkt_words[i];
      s_axis_tlast  = (i == n - 1);
      s_axis_tkeep  = (i == n - 1) ? pkt_keep : 4'hF;
      acc = s_axis_tready;
      @(negedge clk);
      guard++;
      if (acc) begin
        i++;
        ready_for_snooper = 1'b0;
        if (i < n) begin
          for (int g = 0; g < pkt_gap; g++) begin
            s_axis_tvalid = 1'b0;
            @(negedge clk);
          end
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (i < n) chk("send_timeout", i, n);
  endtask

  task automatic run_packet(input int tag, input int exp_wr, input int exp_len, input bit exp_tr);
    int n;
    int guard;
    string t;
    t = $sformatf("p%0d", tag);
    n = pkt_words.size();
    wr_q.delete();
    done_q.delete();
    send_packet();
    chk({t, "_tready_after_last"}, s_axis_tready, 0);
    guard = 0;
    while (done_q.size() == 0 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk({t, "_done_count"}, done_q.size(), 1);
    chk({t, "_write_count"}, wr_q.size(), exp_wr);
    for (int i = 0; i < wr_q.size() && i < exp_wr; i++) begin
      chk($sformatf("%s_write%0d_addr_data", t, i),
          (longint'(wr_q[i].addr) << 32) | longint'(wr_q[i].data),
          (longint'(i) << 32) | longint'(pkt_words[i]));
    end
    if (done_q.size() > 0) begin
      chk({t, "_len"}, done_q[0].len, exp_len);
      chk({t, "_trunc"}, done_q[0].trunc, exp_tr);
      if (exp_wr == n && wr_q.size() > 0)
        chk({t, "_done_latency"}, done_q[0].cyc - wr_q[wr_q.size()-1].cyc, 1);
    end
  endtask

  initial begin
    int bad;
    int n;
    int e_wr;
    int e_len;
    bit e_tr;
    int acc_beats;
    int guard;
    bit acc;

    vecs[0] = '{11, 4'hF, 0, 32'hDEADBEEF, 32'hFFFFFFFF, 11, 44, 1'b0};
    vecs[1] = '{14, 4'hC, 0, 32'h70B31760, 32'h0000FFFF, 14, 54, 1'b0};
    vecs[2] = '{20, 4'hF, 0, 32'h11111111, 32'h22222222, 16, 64, 1'b1};
    vecs[3] = '{3,  4'hF, 1, 32'hA0000000, 32'hA0000002, 3,  12, 1'b0};
    vecs[4] = '{16, 4'hE, 0, 32'h00000005, 32'h12345678, 16, 63, 1'b0};
    vecs[5] = '{1,  4'h0, 0, 32'h0BADF00D, 32'hCAFEF00D, 0,  0,  1'b0};
    vecs[6] = '{2,  4'h8, 2, 32'h01020304, 32'h05060708, 2,  5,  1'b0};
    vecs[7] = '{17, 4'h8, 0, 32'h40000000, 32'h4000FFFF, 16, 64, 1'b1};
    vecs[8] = '{1,  4'hF, 0, 32'h87654321, 32'h13579BDF, 1,  4,  1'b0};

    rst               = 1'b0;
    ready_for_snooper = 1'b0;
    s_axis_tvalid     = 1'b0;
    s_axis_tlast      = 1'b0;
    s_axis_tkeep      = 4'h0;
    s_axis_tdata      = 32'h0;
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      pkt_words.delete();
      for (int i = 0; i < vecs[v].n; i++)
        pkt_words.push_back((i == vecs[v].n - 1) ? vecs[v].last : vecs[v].first + 32'(i));
      pkt_keep = vecs[v].keep;
      pkt_gap  = vecs[v].gap;
      run_packet(v, vecs[v].exp_wr, vecs[v].exp_len, vecs[v].exp_tr);
    end

    // Stall: ready withheld while a beat is offered.
    wr_q.delete();
    done_q.delete();
    pkt_words.delete();
    for (int i = 0; i < 4; i++) pkt_words.push_back(32'hC0DE0000 + 32'(i));
    pkt_keep = 4'hF;
    pkt_gap  = 0;
    ready_for_snooper = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = pkt_words[0];
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = 4'hF;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (s_axis_tready || snooper_wr_en) bad++;
    end
    chk("stall_quiet_cycles", bad, 0);
    chk("stall_writes", wr_q.size(), 0);
    ready_for_snooper = 1'b1;
    @(negedge clk);
    #1;
    chk("stall_tready_next", s_axis_tready, 1);
    run_packet(50, 4, 16, 1'b0);

    // Reset after 5 beats of a 10-beat packet.
    wr_q.delete();
    done_q.delete();
    ready_for_snooper = 1'b1;
    acc_beats = 0;
    guard = 0;
    while (acc_beats < 5 && guard < 100) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'hBEEF0000 + 32'(acc_beats);
      s_axis_tlast  = 1'b0;
      s_axis_tkeep  = 4'hF;
      acc = s_axis_tready;
      @(negedge clk);
      guard++;
      if (acc) begin
        acc_beats++;
        ready_for_snooper = 1'b0;
      end
    end
    chk("midrst_beats_taken", acc_beats, 5);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("midrst_no_done", done_q.size(), 0);
    pkt_words.delete();
    pkt_words.push_back(32'hAAAA5555);
    pkt_words.push_back(32'h5555AAAA);
    pkt_keep = 4'hF;
    pkt_gap  = 0;
    run_packet(60, 2, 8, 1'b0);

    // Random packets against the packet-level model.
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 20);
      pkt_words.delete();
      for (int i = 0; i < n; i++) pkt_words.push_back($urandom);
      case ($urandom_range(0, 4))
        0:       pkt_keep = 4'h0;
        1:       pkt_keep = 4'h8;
        2:       pkt_keep = 4'hC;
        3:       pkt_keep = 4'hE;
        default: pkt_keep = 4'hF;
      endcase
      pkt_gap = $urandom_range(0, 2);
      e_wr = (n > CAP) ? CAP : n;
      if (n <= CAP && pkt_keep == 4'h0) e_wr = e_wr - 1;
      e_len = 4 * (n - 1) + lead_bytes(pkt_keep);
      if (e_len > 4 * CAP) e_len = 4 * CAP;
      e_tr = (n > CAP);
      run_packet(100 + r, e_wr, e_len, e_tr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
